// File: rtl/seq_left_shifter.sv
// Multi-cycle signed left shifter: loads a word, shifts left one bit per clock, flags signed overflow.
// Optional saturation on overflow is enabled by defining SEQ_SHL_SAT_EN.
module seq_left_shifter #(
  parameter int N       = 8,
  parameter int SHAMT_W = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               ser_in,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       dout,
  output logic               ser_out,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] N_CNT = SHAMT_W'(N);

  state_t             state_reg, state_next;
  logic [N-1:0]       shift_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic               ovf_acc_reg;
  logic [N-1:0]       dout_reg;
  logic               ovf_out_reg;

  logic [SHAMT_W-1:0] shamt_clamped;
  logic [N-1:0]       shifted;
  logic               step_ovf;
  logic               start_acc;
  logic               finish_shift;
  logic               done_entry;
  logic [N-1:0]       final_raw;
  logic               final_ovf;
  logic [N-1:0]       final_result;

  assign shamt_clamped = (shamt > N_CNT) ? N_CNT : shamt;
  assign shifted       = {shift_reg[N-2:0], ser_in};
  // A step loses the sign whenever the two top bits differ before the shift
  assign step_ovf      = shift_reg[N-1] ^ shift_reg[N-2];
  assign start_acc     = (state_reg == IDLE) && start;
  assign finish_shift  = (state_reg == SHIFT) && (cnt_reg == SHAMT_W'(1));
  assign done_entry    = (start_acc && (shamt_clamped == '0)) || finish_shift;

  // A zero-length request goes straight to DONE with the operand unchanged
  assign final_raw = start_acc ? din : shifted;
  assign final_ovf = start_acc ? 1'b0 : (ovf_acc_reg | step_ovf);

`ifdef SEQ_SHL_SAT_EN
  logic sign_reg;
  logic final_sign;

  assign final_sign = start_acc ? din[N-1] : sign_reg;

  always_comb begin
    final_result = final_raw;
    if (final_ovf) begin
      final_result = final_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_reg <= 1'b0;
    end else if (start_acc) begin
      sign_reg <= din[N-1];
    end
  end
`else
  assign final_result = final_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (shamt_clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      cnt_reg     <= '0;
      ovf_acc_reg <= 1'b0;
      dout_reg    <= '0;
      ovf_out_reg <= 1'b0;
    end else begin
      if (start_acc) begin
        shift_reg   <= din;
        cnt_reg     <= shamt_clamped;
        ovf_acc_reg <= 1'b0;
      end else if (state_reg == SHIFT) begin
        shift_reg <= shifted;
        cnt_reg   <= cnt_reg - SHAMT_W'(1);
        if (step_ovf) begin
          ovf_acc_reg <= 1'b1;
        end
      end
      // Results are published only on entry to DONE so they hold through the next operation
      if (done_entry) begin
        dout_reg    <= final_result;
        ovf_out_reg <= final_ovf;
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign ser_out  = (state_reg == SHIFT) ? shift_reg[N-1] : 1'b0;
  assign dout     = dout_reg;
  assign overflow = ovf_out_reg;

endmodule
